// File: rtl/bus_frame_receiver_if.sv
// bus_frame_receiver_if
// Groups the serial bus line, node address and frame-result outputs of
// bus_frame_receiver into one bundle.
//   bus      : serial line, one bit per clock, idles at 1
//   addr     : this node's address, only its value at the stop bit matters
//   data_out : payload of the last accepted frame
//   src_out  : source address of the last accepted frame
//   mod_out  : mode field of the last accepted frame
//   valid    : one-cycle pulse, accepted frame with good CRC
//   crc_err  : one-cycle pulse, addressed frame with bad CRC or bad stop bit
//   busy     : a frame is being received
// master = the side that drives the line, slave = the receiver.
interface bus_frame_receiver_if;
    logic        bus;
    logic [3:0]  addr;
    logic [63:0] data_out;
    logic [3:0]  src_out;
    logic [1:0]  mod_out;
    logic        valid;
    logic        crc_err;
    logic        busy;

    modport master (
        output bus, addr,
        input  data_out, src_out, mod_out, valid, crc_err, busy
    );

    modport slave (
        input  bus, addr,
        output data_out, src_out, mod_out, valid, crc_err, busy
    );
endinterface

// File: rtl/bus_frame_receiver.sv
// bus_frame_receiver
// Receives 80-bit serial frames, MSB first per field:
//   start(0) dst[3:0] src[3:0] mod[1:0] data[63:0] crc[3:0] stop(1)
// A running CRC-4 covers dst/src/mod/data; the received crc field is kept
// separately and compared at the stop bit.  Frames addressed to this node
// (dst == addr or broadcast mode 01, and mode not reserved 1x) either load
// the outputs and pulse valid, or pulse crc_err on a CRC/stop-bit failure.
// Ports:
//   clock : system clock, rising edge
//   reset : asynchronous, active high
//   bif   : bus_frame_receiver_if.slave (bus, addr in; results out)
//
// state | meaning
// IDLE  | waiting for a 0 on the bus (start bit)
// HDR   | shifting dst, src, mod (10 bits)
// PAY   | shifting data (64 bits)
// CRC   | shifting the received crc field (4 bits)
// STOP  | sampling stop bit, deciding accept / error / drop
module bus_frame_receiver #(
    parameter logic [3:0] CRC_POLY = 4'b0011
) (
    input  logic                 clock,
    input  logic                 reset,
    bus_frame_receiver_if.slave  bif
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR  = 3'd1,
        ST_PAY  = 3'd2,
        ST_CRC  = 3'd3,
        ST_STOP = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [6:0]  cnt_q, cnt_d;
    logic [3:0]  crc_q, crc_d;
    logic [3:0]  rx_crc_q, rx_crc_d;
    logic [9:0]  hdr_q, hdr_d;
    logic [63:0] pay_q, pay_d;
    logic [63:0] data_out_q, data_out_d;
    logic [3:0]  src_out_q, src_out_d;
    logic [1:0]  mod_out_q, mod_out_d;
    logic        valid_q, valid_d;
    logic        crc_err_q, crc_err_d;
    logic        stop_seen_q, stop_seen_d;

    logic        crc_fb;
    logic [3:0]  crc_next;
    logic [3:0]  hdr_dst;
    logic [3:0]  hdr_src;
    logic [1:0]  hdr_mod;
    logic        addressed;
    logic        frame_good;

    assign hdr_dst = hdr_q[9:6];
    assign hdr_src = hdr_q[5:2];
    assign hdr_mod = hdr_q[1:0];

    // One CRC step for the bit currently on the bus.
    assign crc_fb   = crc_q[3] ^ bif.bus;
    assign crc_next = {crc_q[2:0], 1'b0} ^ (crc_fb ? CRC_POLY : 4'b0000);

    // Evaluated in STOP; addr is read live so only its stop-bit value counts.
    assign addressed  = ((hdr_dst == bif.addr) || (hdr_mod == 2'b01)) && !hdr_mod[1];
    assign frame_good = bif.bus && (crc_q == rx_crc_q);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            crc_q       <= '0;
            rx_crc_q    <= '0;
            hdr_q       <= '0;
            pay_q       <= '0;
            data_out_q  <= '0;
            src_out_q   <= '0;
            mod_out_q   <= '0;
            valid_q     <= 1'b0;
            crc_err_q   <= 1'b0;
            stop_seen_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            crc_q       <= crc_d;
            rx_crc_q    <= rx_crc_d;
            hdr_q       <= hdr_d;
            pay_q       <= pay_d;
            data_out_q  <= data_out_d;
            src_out_q   <= src_out_d;
            mod_out_q   <= mod_out_d;
            valid_q     <= valid_d;
            crc_err_q   <= crc_err_d;
            stop_seen_q <= stop_seen_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + 7'd1;
        crc_d       = crc_q;
        rx_crc_d    = rx_crc_q;
        hdr_d       = hdr_q;
        pay_d       = pay_q;
        data_out_d  = data_out_q;
        src_out_d   = src_out_q;
        mod_out_d   = mod_out_q;
        valid_d     = 1'b0;
        crc_err_d   = 1'b0;
        stop_seen_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (!bif.bus) begin
                    state_d = ST_HDR;
                    crc_d   = '0;
                end
            end
            ST_HDR: begin
                crc_d = crc_next;
                hdr_d = {hdr_q[8:0], bif.bus};
                if (cnt_q == 7'd9) begin
                    state_d = ST_PAY;
                    cnt_d   = '0;
                end
            end
            ST_PAY: begin
                crc_d = crc_next;
                pay_d = {pay_q[62:0], bif.bus};
                if (cnt_q == 7'd63) begin
                    state_d = ST_CRC;
                    cnt_d   = '0;
                end
            end
            ST_CRC: begin
                rx_crc_d = {rx_crc_q[2:0], bif.bus};
                if (cnt_q == 7'd3) begin
                    state_d = ST_STOP;
                    cnt_d   = '0;
                end
            end
            ST_STOP: begin
                state_d     = ST_IDLE;
                cnt_d       = '0;
                stop_seen_d = 1'b1;
                if (addressed) begin
                    if (frame_good) begin
                        valid_d    = 1'b1;
                        data_out_d = pay_q;
                        src_out_d  = hdr_src;
                        mod_out_d  = hdr_mod;
                    end else begin
                        crc_err_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign bif.data_out = data_out_q;
    assign bif.src_out  = src_out_q;
    assign bif.mod_out  = mod_out_q;
    assign bif.valid    = valid_q;
    assign bif.crc_err  = crc_err_q;
    // In the cycle right after the stop bit the FSM is back in IDLE, but if
    // the next start bit is already on the line the frame stream has not
    // paused, so busy is held to keep it continuous across back-to-back frames.
    assign bif.busy     = (state_q != ST_IDLE) || (stop_seen_q && !bif.bus);

endmodule
